// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART RX oversampling front end.
package uart_rx_pkg;

  localparam int PRESCALE_W       = 6;
  localparam int BIT_CNT_W        = 4;
  localparam int PRESCALE_DEFAULT = 8;
  localparam int PRESCALE_MIN     = 6;
  localparam int PRESCALE_MAX     = 32;

  // Frame layout: start, data bits, optional parity, stop.
  function automatic int frame_bits(input int data_w, input int parity_en);
    return 1 + data_w + parity_en + 1;
  endfunction

  localparam int START_IDX = 0;
  localparam int STOP_IDX  = frame_bits(8, 1) - 1;

  // Only even ratios in the supported range give a centred three-sample window.
  function automatic logic prescale_legal(input int unsigned p);
    return (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX) && (p[0] == 1'b0);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter with the frame_done pulse.
module uart_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = PRESCALE_W,
  parameter int Frame_bits     = frame_bits(8, 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [Prescale_width-1:0] prescale,
  output logic [Prescale_width-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]      bit_cnt,
  output logic                      frame_done
);

  localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(Frame_bits - 1);
  localparam logic [BIT_CNT_W-1:0]      FIRST_BIT = BIT_CNT_W'(START_IDX);
  localparam logic [Prescale_width-1:0] EDGE_ONE = Prescale_width'(1);
  localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = BIT_CNT_W'(1);

  logic last_edge;
  logic last_bit;

  assign last_edge = (edge_cnt == prescale - EDGE_ONE);
  assign last_bit  = (bit_cnt == LAST_BIT);

  // Dropping enable is an abort: counters clear and no frame_done escapes.
  always_ff @(posedge CLK) begin
    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    if (RST || !enable) begin
      edge_cnt   <= '0;
      bit_cnt    <= FIRST_BIT;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (last_edge) begin
        edge_cnt <= '0;
        if (last_bit) begin
          bit_cnt    <= FIRST_BIT;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BIT_ONE;
        end
      end else begin
        edge_cnt <= edge_cnt + EDGE_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampler: latches the prescale, counts edges/bits, majority-votes mid-bit.
// Optional input synchronizer enabled by defining UART_RX_SAMPLER_SYNC_EN.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int Data_width     = 8,
  parameter int Parity_en      = 1,
  parameter int Prescale_width = PRESCALE_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      RX_IN,
  input  logic [Prescale_width-1:0] Prescale,
  output logic [Prescale_width-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]      bit_cnt,
  output logic                      sampled_bit,
  output logic                      sample_valid,
  output logic                      frame_done
);

  localparam int                        FRAME_BITS = frame_bits(Data_width, Parity_en);
  localparam logic [Prescale_width-1:0] P_DEFAULT  = Prescale_width'(PRESCALE_DEFAULT);
  localparam logic [Prescale_width-1:0] EDGE_ONE   = Prescale_width'(1);

  logic                      rx_s;
  logic [Prescale_width-1:0] prescale_q;
  logic [Prescale_width-1:0] half;
  logic                      cap_s0;
  logic                      cap_s1;
  logic                      cap_vote;
  logic                      s0;
  logic                      s1;

`ifdef UART_RX_SAMPLER_SYNC_EN
  logic [1:0] rx_sync;

  // Idle-high reset value keeps the line from looking like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], RX_IN};
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = RX_IN;
`endif

  // Ratio is frozen for the whole frame; illegal requests fall back to the default.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_q <= P_DEFAULT;
    end else if (!enable) begin
      prescale_q <= prescale_legal(32'(Prescale)) ? Prescale : P_DEFAULT;
    end
  end

  uart_edge_bit_counter #(
    .Prescale_width (Prescale_width),
    .Frame_bits     (FRAME_BITS)
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .prescale   (prescale_q),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done)
  );

  assign half = prescale_q >> 1;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    cap_s0   = 1'b0;
    cap_s1   = 1'b0;
    cap_vote = 1'b0;
    if (enable) begin
      cap_s0   = (edge_cnt == half - EDGE_ONE);
      cap_s1   = (edge_cnt == half);
      cap_vote = (edge_cnt == half + EDGE_ONE);
    end
  end

  // Third sample is taken live from the line and voted in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0           <= 1'b0;
      s1           <= 1'b0;
      sampled_bit  <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (cap_s0) s0 <= rx_s;
      if (cap_s1) s1 <= rx_s;
      if (cap_vote) begin
        sampled_bit  <= majority3(s0, s1, rx_s);
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Upstream neighbour of the UART RX deserializer. Runs on the oversampling clock.
- Counts oversampling edges per bit and bits per frame.
- Majority-votes three mid-bit samples of RX_IN.
- Drives sampled_bit, bit_cnt and the handshake pulses consumed by the deserializer and the RX FSM (start/parity/stop checkers).

Parameters:
- Data_width, 8, number of data bits per frame.
- Parity_en, 1, 1 adds one parity bit to the frame; frame length FRAME_BITS = 1 + Data_width + Parity_en + 1.
- Prescale_width, 6, width of the Prescale input and edge_cnt.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  reset; synchronous, active-high.
- enable  input  1  from RX FSM; high while a frame is being received.
- RX_IN  input  1  serial line; idle high.
- Prescale  input  Prescale_width  oversampling ratio; legal even values 6..32.
- edge_cnt  output  Prescale_width  edge index within the current bit.
- bit_cnt  output  4  bit index within the frame: 0 = start, 1..Data_width = data, then parity, then stop.
- sampled_bit  output  1  majority-voted value of the current bit.
- sample_valid  output  1  one-cycle pulse; sampled_bit is updated and stable in the same cycle.
- frame_done  output  1  one-cycle pulse on the last edge of the stop bit.

Behaviour:
- Reset: RST is synchronous and active-high. At a CLK edge with RST high, all outputs go to 0 and the internal prescale latch goes to 8. Reset overrides enable mid-frame; no frame_done is produced.
- Prescale latch:
  - Loaded from Prescale on every cycle with enable low.
  - Held constant while enable is high; Prescale changes mid-frame are ignored.
  - P below is the latched value.
- enable low: edge_cnt, bit_cnt, sample_valid and frame_done are 0 from the next edge. sampled_bit holds its value.
- edge_cnt:
  - With enable high, edge_cnt increments each cycle.
  - At edge_cnt == P-1 it wraps to 0 and bit_cnt increments.
- bit_cnt: at edge_cnt == P-1 with bit_cnt == FRAME_BITS-1, frame_done = 1 on the next cycle and bit_cnt wraps to 0. Back-to-back frames need no gap.
- Sampling, with H = P/2:
  - RX_IN is captured into s0, s1, s2 on the cycles where edge_cnt == H-1, H and H+1.
  - On the cycle edge_cnt == H+1, the registered output takes sampled_bit = majority(s0, s1, RX_IN) and sample_valid = 1, both visible at the following edge.
  - Latency from the third sample to the output is 1 cycle.
- Deserializer compatibility: bit_cnt is held constant from the sample_valid pulse until the next wrap. A downstream write to index bit_cnt-1 therefore targets the correct data bit.
- Abort: enable falling mid-frame
  - clears the counters on the next edge,
  - suppresses any pending sample_valid,
  - produces no frame_done.
- Simultaneous: enable rising on the same edge as RST high means reset wins.
- Illegal Prescale values: odd values, values below 6, or values above 32 are clamped to 8 when latched.

Optional Feature:
- Macro: UART_RX_SAMPLER_SYNC_EN.
- Defined:
  - RX_IN passes through a 2-flop synchronizer, reset to 1, before sampling.
  - Sample positions are unchanged relative to the synchronized signal.
  - End-to-end latency from the pin is +2 cycles.
- Undefined: RX_IN is sampled directly; RX_IN is assumed synchronous to CLK.

Decomposition:
- Package uart_rx_pkg holds:
  - PRESCALE_W = 6, BIT_CNT_W = 4;
  - the frame_bits(Data_width, Parity_en) function;
  - the legal-prescale check;
  - the bit-index constants START_IDX = 0 and STOP_IDX.
- Sub-module uart_edge_bit_counter: edge_cnt/bit_cnt wrap logic and the frame_done pulse.
- The voter and synchronizer stay in the top module.

Test Plan:
- Prescale = 8, frame 0x55 with parity, no gaps:
  - sample_valid pulses 11 times, 8 cycles apart;
  - data bits on bit_cnt 1..8 are 1,0,1,0,1,0,1,0 (LSB first);
  - frame_done pulses once, 88 cycles after enable rises.
- Prescale = 16, one-cycle glitch on RX_IN at edge_cnt == 8 inside data bit 3 (value 1):
  - sampled_bit == 1 (majority);
  - a two-cycle glitch over edges 8 and 9 gives 0.
- Prescale = 32, enable dropped at bit_cnt == 4, edge_cnt == 10:
  - next cycle edge_cnt == 0 and bit_cnt == 0;
  - no sample_valid for bit 4 and no frame_done.
- Prescale changed 8 -> 16 mid-frame: bit period stays 8 cycles until enable falls; the next frame uses 16.
- RST asserted at edge_cnt == 5, bit_cnt == 2: all outputs are 0 on the next edge; resuming enable restarts at bit_cnt == 0.
- With UART_RX_SAMPLER_SYNC_EN: the same 0x55 frame yields identical sampled_bit values, with the first sample_valid 2 cycles later relative to the RX_IN edge.
